// File: rtl/doodle_pkg.sv
// Shared constants and types for the Doodle Jump core: motion FSM states,
// keyboard keycodes, game-state encodings and a horizontal step helper.
package doodle_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2,
        DEAD = 2'd3
    } motion_state_t;

    localparam logic [7:0] KEY_A     = 8'd4;
    localparam logic [7:0] KEY_D     = 8'd7;
    localparam logic [7:0] KEY_ESC   = 8'd41;
    localparam logic [7:0] KEY_ENTER = 8'd40;

    localparam logic [7:0] GS_MENU = 8'd0;
    localparam logic [7:0] GS_PLAY = 8'd1;

    // Horizontal step with screen wrap: stepping past the left edge lands on
    // x_max, stepping past x_max lands on 0. The sum is 11 bits so that a
    // borrow or carry is visible.
    function automatic logic [9:0] step_x(input logic [9:0] x,
                                          input logic [7:0] key,
                                          input logic [9:0] x_max,
                                          input logic [9:0] x_step);
        logic [10:0] sum_s;
        sum_s  = 11'd0;
        step_x = x;
        case (key)
            KEY_A: begin
                sum_s = {1'b0, x} - {1'b0, x_step};
                if (sum_s[10]) begin
                    step_x = x_max;
                end else begin
                    step_x = sum_s[9:0];
                end
            end
            KEY_D: begin
                sum_s = {1'b0, x} + {1'b0, x_step};
                if (sum_s > {1'b0, x_max}) begin
                    step_x = 10'd0;
                end else begin
                    step_x = sum_s[9:0];
                end
            end
            default: step_x = x;
        endcase
    endfunction

endpackage

// File: rtl/doodle_motion_if.sv
// Bundle between the game-state/input logic and the doodle motion block.
interface doodle_motion_if;
    logic [7:0] state;
    logic [7:0] keycode;
    logic       land;
    logic [9:0] doodle_x;
    logic [9:0] doodle_y;
    logic       falling;
    logic       game_over;

    modport master (
        output state, keycode, land,
        input  doodle_x, doodle_y, falling, game_over
    );

    modport slave (
        input  state, keycode, land,
        output doodle_x, doodle_y, falling, game_over
    );
endinterface

// File: rtl/doodle_motion_frame_edge_detect.sv
// One-Clk pulse on each rising edge of the vertical-sync-rate frame clock.
// A frame_clk held high yields a single tick.
module frame_edge_detect (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);
    logic frame_clk_d;

    // Delay frame_clk by one Clk to find its rising edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_clk_d <= 1'b0;
        end else begin
            frame_clk_d <= frame_clk;
        end
    end

    assign tick = frame_clk & ~frame_clk_d;
endmodule

// File: rtl/doodle_motion.sv
// Per-frame doodle kinematics: jump impulse, gravity, floor death and
// horizontal wrap, advanced once per frame tick.
module doodle_motion
    import doodle_pkg::*;
#(
    parameter logic [9:0] X_MAX     = 10'd639,
    parameter logic [9:0] Y_MAX     = 10'd479,
    parameter logic [9:0] X_START   = 10'd320,
    parameter logic [9:0] Y_START   = 10'd400,
    parameter logic [9:0] X_STEP    = 10'd2,
    parameter logic [4:0] JUMP_VEL  = 5'd12,
    parameter logic [4:0] GRAVITY   = 5'd1,
    parameter logic [4:0] VMAX_FALL = 5'd12
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            frame_clk,
    doodle_motion_if.slave  bus
);
    motion_state_t motion_state_r, state_nxt_s;
    logic [9:0]  x_r, y_r, x_nxt_s, y_nxt_s;
    logic [4:0]  vel_r, vel_nxt_s;
    logic [10:0] y_sum_s;
    logic [5:0]  vel_sum_s;
    logic        falling_r, game_over_r;
    logic        tick_s;

    frame_edge_detect u_edge (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (tick_s)
    );

    // State, position and velocity registers; flags track the next state so
    // they line up with the position they describe.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            motion_state_r <= IDLE;
            x_r            <= X_START;
            y_r            <= Y_START;
            vel_r          <= 5'd0;
            falling_r      <= 1'b0;
            game_over_r    <= 1'b0;
        end else begin
            motion_state_r <= state_nxt_s;
            x_r            <= x_nxt_s;
            y_r            <= y_nxt_s;
            vel_r          <= vel_nxt_s;
            falling_r      <= (state_nxt_s == FALL);
            game_over_r    <= (state_nxt_s == DEAD);
        end
    end

    // Next-state and kinematics; leaving play overrides any tick action.
    always_comb begin
        state_nxt_s = motion_state_r;
        x_nxt_s     = x_r;
        y_nxt_s     = y_r;
        vel_nxt_s   = vel_r;
        y_sum_s     = 11'd0;
        vel_sum_s   = 6'd0;
        if ((bus.state != GS_PLAY) && (motion_state_r != IDLE)) begin
            state_nxt_s = IDLE;
            x_nxt_s     = X_START;
            y_nxt_s     = Y_START;
            vel_nxt_s   = 5'd0;
        end else if (tick_s) begin
            case (motion_state_r)
                IDLE: begin
                    x_nxt_s   = X_START;
                    y_nxt_s   = Y_START;
                    if (bus.state == GS_PLAY) begin
                        state_nxt_s = RISE;
                        vel_nxt_s   = JUMP_VEL;
                    end else begin
                        vel_nxt_s   = 5'd0;
                    end
                end
                RISE: begin
                    x_nxt_s = step_x(x_r, bus.keycode, X_MAX, X_STEP);
                    y_sum_s = {1'b0, y_r} - {6'd0, vel_r};
                    if (y_sum_s[10]) begin
                        y_nxt_s = 10'd0;
                    end else begin
                        y_nxt_s = y_sum_s[9:0];
                    end
                    if (vel_r > GRAVITY) begin
                        vel_nxt_s = vel_r - GRAVITY;
                    end else begin
                        vel_nxt_s = 5'd0;
                    end
                    if (vel_nxt_s == 5'd0) begin
                        state_nxt_s = FALL;
                    end else begin
                        state_nxt_s = RISE;
                    end
                end
                FALL: begin
                    x_nxt_s = step_x(x_r, bus.keycode, X_MAX, X_STEP);
                    if (bus.land) begin
                        state_nxt_s = RISE;
                        vel_nxt_s   = JUMP_VEL;
                    end else begin
                        y_sum_s = {1'b0, y_r} + {6'd0, vel_r};
                        if (y_sum_s >= {1'b0, Y_MAX}) begin
                            y_nxt_s     = Y_MAX;
                            state_nxt_s = DEAD;
                        end else begin
                            y_nxt_s   = y_sum_s[9:0];
                            vel_sum_s = {1'b0, vel_r} + {1'b0, GRAVITY};
                            if (vel_sum_s > {1'b0, VMAX_FALL}) begin
                                vel_nxt_s = VMAX_FALL;
                            end else begin
                                vel_nxt_s = vel_sum_s[4:0];
                            end
                        end
                    end
                end
                DEAD: begin
                    state_nxt_s = DEAD;
                end
                default: begin
                    state_nxt_s = IDLE;
                    x_nxt_s     = X_START;
                    y_nxt_s     = Y_START;
                    vel_nxt_s   = 5'd0;
                end
            endcase
        end else begin
            state_nxt_s = motion_state_r;
        end
    end

    assign bus.doodle_x  = x_r;
    assign bus.doodle_y  = y_r;
    assign bus.falling   = falling_r;
    assign bus.game_over = game_over_r;
endmodule

// File: tb/tb_doodle_motion.sv
// Directed bench for doodle_motion: launch, landing, death, wrap,
// single update per frame, asynchronous reset and menu override.
module tb_doodle_motion;
    logic Clk;
    logic Reset;
    logic frame_clk;
    int   pass_cnt;
    int   check_cnt;

    doodle_motion_if bus ();

    doodle_motion dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .bus       (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        check_cnt++;
        if (obs == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame: frame_clk high for one Clk, then low; ends on a negedge.
    task automatic do_tick();
        @(negedge Clk) frame_clk = 1'b1;
        @(negedge Clk) frame_clk = 1'b0;
        @(negedge Clk);
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic check_pos(input string tag, input int ex, input int ey);
        check_val({tag, "_x"}, int'(bus.doodle_x), ex);
        check_val({tag, "_y"}, int'(bus.doodle_y), ey);
    endtask

    initial begin
        pass_cnt    = 0;
        check_cnt   = 0;
        Reset       = 1'b1;
        frame_clk   = 1'b0;
        bus.state   = 8'd0;
        bus.keycode = 8'd0;
        bus.land    = 1'b0;
        repeat (2) @(negedge Clk);
        check_pos("reset", 320, 400);
        check_val("reset_falling", int'(bus.falling), 0);
        check_val("reset_game_over", int'(bus.game_over), 0);
        Reset = 1'b0;

        // Launch and rise
        @(negedge Clk) bus.state = 8'd1;
        do_tick();
        check_pos("launch", 320, 400);
        do_tick();
        check_val("rise1_y", int'(bus.doodle_y), 388);
        do_ticks(10);
        check_val("rise11_y", int'(bus.doodle_y), 323);
        check_val("rise11_falling", int'(bus.falling), 0);
        do_tick();
        check_val("apex_y", int'(bus.doodle_y), 322);
        check_val("apex_falling", int'(bus.falling), 1);

        // Fall to 350 then land
        do_ticks(8);
        check_val("fall8_y", int'(bus.doodle_y), 350);
        bus.land = 1'b1;
        do_tick();
        bus.land = 1'b0;
        check_val("land_y", int'(bus.doodle_y), 350);
        check_val("land_falling", int'(bus.falling), 0);
        do_tick();
        check_val("land_next_y", int'(bus.doodle_y), 338);

        // Rise to 272, fall to 470, then die on the floor
        do_ticks(11);
        check_val("apex2_y", int'(bus.doodle_y), 272);
        check_val("apex2_falling", int'(bus.falling), 1);
        do_ticks(12);
        check_val("fall12_y", int'(bus.doodle_y), 338);
        do_ticks(11);
        check_val("fall23_y", int'(bus.doodle_y), 470);
        do_tick();
        check_val("death_y", int'(bus.doodle_y), 479);
        check_val("death_game_over", int'(bus.game_over), 1);
        check_val("death_falling", int'(bus.falling), 0);
        do_tick();
        check_val("dead_hold_y", int'(bus.doodle_y), 479);

        // Menu pulse leaves DEAD without a tick
        @(negedge Clk) bus.state = 8'd0;
        @(negedge Clk);
        check_pos("dead_exit", 320, 400);
        check_val("dead_exit_game_over", int'(bus.game_over), 0);
        bus.state = 8'd1;

        // Horizontal wrap while bouncing on a permanent platform
        bus.keycode = 8'd7;
        bus.land    = 1'b1;
        do_tick();
        check_val("wrap_launch_x", int'(bus.doodle_x), 320);
        do_ticks(159);
        check_val("wrap_638_x", int'(bus.doodle_x), 638);
        do_tick();
        check_val("wrap_right_x", int'(bus.doodle_x), 0);
        bus.keycode = 8'd4;
        do_tick();
        check_val("wrap_left0_x", int'(bus.doodle_x), 639);
        do_ticks(319);
        check_val("wrap_1_x", int'(bus.doodle_x), 1);
        do_tick();
        check_val("wrap_left1_x", int'(bus.doodle_x), 639);
        bus.keycode = 8'd0;
        bus.land    = 1'b0;

        // Back to spawn, then frame_clk held high
        @(negedge Clk) bus.state = 8'd0;
        @(negedge Clk) bus.state = 8'd1;
        check_pos("respawn", 320, 400);
        do_tick();
        @(negedge Clk) frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        check_val("held_early_y", int'(bus.doodle_y), 388);
        repeat (97) @(negedge Clk);
        check_val("held_late_y", int'(bus.doodle_y), 388);
        frame_clk = 1'b0;
        do_tick();
        check_val("after_held_y", int'(bus.doodle_y), 377);

        // Asynchronous reset mid-rise
        @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        check_pos("async_reset", 320, 400);
        check_val("async_reset_falling", int'(bus.falling), 0);
        check_val("async_reset_game_over", int'(bus.game_over), 0);
        @(negedge Clk) Reset = 1'b0;

        // Menu override coinciding with a keyed tick
        do_tick();
        do_tick();
        check_val("ovr_rise_y", int'(bus.doodle_y), 388);
        @(negedge Clk);
        bus.keycode = 8'd7;
        bus.state   = 8'd0;
        frame_clk   = 1'b1;
        @(negedge Clk);
        check_pos("menu_override", 320, 400);
        check_val("menu_override_falling", int'(bus.falling), 0);
        frame_clk   = 1'b0;
        bus.keycode = 8'd0;
        repeat (2) @(negedge Clk);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
